// File: rtl/data_store_pkg.sv
// Shared types and widths for the per-channel ping-pong sample store.
// Address layout is {chan, half, word}.
package data_store_pkg;
   localparam int DATA_W = 64;
   localparam int IDX_W  = 7;
   localparam int HALF_W = 4;
   localparam int ADDR_W = IDX_W + HALF_W + 1;
   localparam int NCH    = 1 << IDX_W;

   typedef struct packed {
      logic             half;
      logic [IDX_W-1:0] chan;
   } req_t;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } rd_state_e;
endpackage

// File: rtl/ds_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-first: a read of the address being written returns the old word.
module ds_dpram #(
   parameter int DW = 64,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [1<<AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/data_store_transfer.sv
// Per-channel ping-pong sample store: full halves are queued as burst
// requests and streamed out as tagged 16-word bursts.
module data_store_transfer
   import data_store_pkg::*;
#(
   parameter int REQ_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [IDX_W-1:0]  index,
   input  logic              valid,
   output logic [DATA_W-1:0] data_out,
   output logic [HALF_W-1:0] data_count,
   output logic [IDX_W-1:0]  data_index,
   output logic              data_valid,
   output logic              overflow
);
   localparam int FA_W = $clog2(REQ_DEPTH);

   // Write pointers: msb selects the half, low bits the word.
   logic [HALF_W:0] wptr_q [NCH];
   logic [HALF_W:0] wptr;
   logic            wr_last;
   req_t            push_req;

   assign wptr     = wptr_q[index];
   assign wr_last  = valid && (wptr[HALF_W-1:0] == '1);
   assign push_req = '{half: wptr[HALF_W], chan: index};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) wptr_q[i] <= '0;
      end else if (valid) begin
         wptr_q[index] <= wptr + 1'b1;
      end
   end

   // Pending-burst FIFO.
   req_t          fifo_mem_q [REQ_DEPTH];
   logic [FA_W:0] fwr_q;
   logic [FA_W:0] frd_q;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          ovf_q;
   req_t          head;

   assign empty   = (fwr_q == frd_q);
   assign full    = (fwr_q[FA_W] != frd_q[FA_W]) &&
                    (fwr_q[FA_W-1:0] == frd_q[FA_W-1:0]);
   assign push_ok = wr_last && (!full || pop);
   assign head    = fifo_mem_q[frd_q[FA_W-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem_q[fwr_q[FA_W-1:0]] <= push_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwr_q <= '0;
         frd_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push_ok) fwr_q <= fwr_q + 1'b1;
         if (pop) frd_q <= frd_q + 1'b1;
         if (wr_last && !push_ok) ovf_q <= 1'b1;
      end
   end

   // Read engine.
   rd_state_e         state_q;
   rd_state_e         state_d;
   req_t              cur_q;
   req_t              cur_d;
   logic [HALF_W-1:0] cnt_q;
   logic [HALF_W-1:0] cnt_d;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   assign rd_addr = {cur_q.chan, cur_q.half, cnt_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cur_d   = head;
               cnt_d   = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            rd_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            // Chain straight into the next burst when one is waiting.
            if (cnt_q == '1) begin
               if (!empty) begin
                  pop   = 1'b1;
                  cur_d = head;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic [DATA_W-1:0] ram_q;

   ds_dpram #(
      .DW(DATA_W),
      .AW(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .we_i   (valid),
      .waddr_i({index, wptr}),
      .wdata_i(data_in),
      .re_i   (rd_en),
      .raddr_i(rd_addr),
      .rdata_o(ram_q)
   );

   // Tags travel alongside the RAM read, then everything is registered.
   logic              s1_vld_q;
   logic [HALF_W-1:0] s1_cnt_q;
   logic [IDX_W-1:0]  s1_chan_q;
   logic [DATA_W-1:0] dout_q;
   logic [HALF_W-1:0] dcnt_q;
   logic [IDX_W-1:0]  didx_q;
   logic              dv_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_cnt_q  <= '0;
         s1_chan_q <= '0;
         dout_q    <= '0;
         dcnt_q    <= '0;
         didx_q    <= '0;
         dv_q      <= 1'b0;
      end else begin
         s1_vld_q  <= rd_en;
         s1_cnt_q  <= cnt_q;
         s1_chan_q <= cur_q.chan;
         dv_q      <= s1_vld_q;
         if (s1_vld_q) begin
            dout_q <= ram_q;
            dcnt_q <= s1_cnt_q;
            didx_q <= s1_chan_q;
         end
      end
   end

   assign data_out   = dout_q;
   assign data_count = dcnt_q;
   assign data_index = didx_q;
   assign data_valid = dv_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_data_store_transfer.sv
// Bench for data_store_transfer: per-channel write-order scoreboard,
// directed vector table and multi-cycle timing sequences.
module tb_data_store_transfer;
   logic        clk;
   logic        rst;
   logic [63:0] data_in;
   logic [6:0]  index;
   logic        valid;
   logic [63:0] data_out;
   logic [3:0]  data_count;
   logic [6:0]  data_index;
   logic        data_valid;
   logic        overflow;

   logic [63:0] s_data_in;
   logic [6:0]  s_index;
   logic        s_valid;
   logic [63:0] s_data_out;
   logic [3:0]  s_data_count;
   logic [6:0]  s_data_index;
   logic        s_data_valid;
   logic        s_overflow;

   data_store_transfer dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .index     (index),
      .valid     (valid),
      .data_out  (data_out),
      .data_count(data_count),
      .data_index(data_index),
      .data_valid(data_valid),
      .overflow  (overflow)
   );

   data_store_transfer #(.REQ_DEPTH(4)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .data_in   (s_data_in),
      .index     (s_index),
      .valid     (s_valid),
      .data_out  (s_data_out),
      .data_count(s_data_count),
      .data_index(s_data_index),
      .data_valid(s_data_valid),
      .overflow  (s_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  c;
      logic [6:0]  ch;
   } word_t;

   typedef struct {
      int idx;
      int nwr;
      int exp_words;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nwords = 0;
   int nbursts = 0;
   int first_dv = -1;
   int last_dv = -1;
   int s_words = 0;

   // Model: each channel collects samples; every 16 form one burst.
   logic [63:0] chbuf [128][16];
   int          chn [128];
   word_t       exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model_clear();
      for (int i = 0; i < 128; i++) chn[i] = 0;
      exp_q.delete();
   endfunction

   function automatic void model_write(int idx, logic [63:0] d);
      chbuf[idx][chn[idx]] = d;
      chn[idx]++;
      if (chn[idx] == 16) begin
         for (int i = 0; i < 16; i++)
            exp_q.push_back({chbuf[idx][i], 4'(i), 7'(idx)});
         chn[idx] = 0;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && data_valid) begin
         word_t e;
         nwords++;
         if (data_count == 4'd0) nbursts++;
         if (first_dv < 0) first_dv = cyc;
         last_dv = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got d=%0h c=%0d ch=%0d",
                     data_out, data_count, data_index);
         end else begin
            e = exp_q.pop_front();
            if (e != {data_out, data_count, data_index}) begin
               errors++;
               $display("FAIL burst_word got d=%0h c=%0d ch=%0d exp d=%0h c=%0d ch=%0d",
                        data_out, data_count, data_index, e.d, e.c, e.ch);
            end
         end
      end
      if (!rst && s_data_valid) s_words++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      valid   = 1'b0;
      s_valid = 1'b0;
      rst     = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [63:0] d);
      data_in = d;
      index   = 7'(idx);
      valid   = 1'b1;
      model_write(idx, d);
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic s_wr(input int idx, input logic [63:0] d);
      s_data_in = d;
      s_index   = 7'(idx);
      s_valid   = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int maxc);
      bit ok = 0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !data_valid) begin
            ok = 1;
            break;
         end
      end
      check({name, "_drain"}, ok, 1);
      idle(5);
   endtask

   vec_t vt [6];

   initial begin
      int n0, b0, wedge, lat, run, bad;
      bit seen;
      vt[0] = '{9, 10, 0};
      vt[1] = '{9, 6, 16};
      vt[2] = '{10, 16, 16};
      vt[3] = '{9, 20, 16};
      vt[4] = '{11, 15, 0};
      vt[5] = '{11, 1, 16};

      data_in = '0; index = '0; valid = 1'b0;
      s_data_in = '0; s_index = '0; s_valid = 1'b0;
      rst = 1'b1;
      model_clear();
      #2;
      check("rst_data_out", data_out, 0);
      check("rst_valid", data_valid, 0);
      check("rst_overflow", overflow, 0);
      do_reset();

      // Directed vector table.
      foreach (vt[v]) begin
         n0 = nwords;
         for (int i = 0; i < vt[v].nwr; i++)
            wr(vt[v].idx, {$urandom, $urandom});
         idle(40);
         check($sformatf("vec%0d_words", v), nwords - n0, vt[v].exp_words);
      end

      // Single channel: latency, burst length, no output for a lone write.
      do_reset();
      n0 = nwords;
      for (int i = 0; i < 16; i++) wr(5, 64'(100 + i));
      wedge = cyc;
      seen = 0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (data_valid) begin
            seen = 1;
            lat = cyc - wedge;
            break;
         end
      end
      check("single_latency", lat, 3);
      run = 0;
      while (seen && data_valid && run < 40) begin
         run++;
         @(negedge clk);
      end
      check("single_run", run, 16);
      check("single_words", nwords - n0, 16);
      #1;
      n0 = nwords;
      wr(5, 64'd999);
      idle(40);
      check("single_17th", nwords - n0, 0);

      // Ping-pong on one channel, then reuse of half 0.
      do_reset();
      n0 = nwords;
      b0 = nbursts;
      for (int i = 0; i < 48; i++) wr(3, 64'(i));
      wait_drain("pingpong", 300);
      check("pingpong_words", nwords - n0, 48);
      check("pingpong_bursts", nbursts - b0, 3);

      // Round-robin stream over all channels.
      do_reset();
      n0 = nwords;
      b0 = nbursts;
      first_dv = -1;
      for (int n = 0; n < 8196; n++) wr(n % 128, 64'(n));
      wait_drain("rr", 6000);
      check("rr_words", nwords - n0, 8192);
      check("rr_bursts", nbursts - b0, 512);
      check("rr_gapless", last_dv - first_dv + 1, 8192);
      check("rr_overflow", overflow, 0);

      // Reset in the middle of a burst.
      do_reset();
      for (int i = 0; i < 16; i++) wr(20, {$urandom, $urandom});
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (data_valid) begin
            seen = 1;
            break;
         end
      end
      check("midrst_started", seen, 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      model_clear();
      #1;
      check("midrst_data_out", data_out, 0);
      check("midrst_count", data_count, 0);
      check("midrst_index", data_index, 0);
      check("midrst_valid", data_valid, 0);
      check("midrst_overflow", overflow, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (data_valid) bad++;
      end
      check("midrst_quiet", bad, 0);
      #1;

      // Overflow on the 4-deep build: six halves completing back to back.
      do_reset();
      for (int c = 0; c < 6; c++)
         for (int i = 0; i < 15; i++) s_wr(c, 64'(c * 16 + i));
      s_words = 0;
      for (int c = 0; c < 5; c++) s_wr(c, 64'(c * 16 + 15));
      check("ovf_before_drop", s_overflow, 0);
      s_wr(5, 64'(95));
      check("ovf_after_drop", s_overflow, 1);
      idle(200);
      check("ovf_words", s_words, 80);
      check("ovf_sticky", s_overflow, 1);

      // Sparse random writes across a few channels.
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 1) == 1)
            wr($urandom_range(0, 7), {$urandom, $urandom});
         else
            idle(1);
      end
      wait_drain("rand", 500);
      check("rand_overflow", overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
